count_updn: RTL

COUNT_UPDN -- requirements
Module: count_updn

---
 rtl/count_pkg.sv | 14 +
 rtl/count_step.sv | 98 +++++++++
 rtl/count_updn.sv | 64 ++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared encodings for the up/down counter: MODE values and the bounce-direction state.
package count_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    // 2'b11 is reserved and decodes as MODE_WRAP.

    typedef enum logic {
        B_UP   = 1'b0,
        B_DOWN = 1'b1
    } bounce_state_e;

endpackage

// File: rtl/count_step.sv
// Combinational next-state logic for count_updn.
// Inputs : current count/dir/bounce state, en/up/mode/load/load_val controls.
// Outputs: next count, terminal-count flag, next effective direction, next bounce state.
module count_step
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 9
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    input  bounce_state_e    bstate_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_c_o,
    output logic             tc_c_o,
    output logic             dir_c_o,
    output bounce_state_e    bstate_c_o
);

    localparam logic [WIDTH-1:0] MAX    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX_VAL - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    // Load beats enable; with neither, everything holds and TC drops.
    always_comb begin
        count_c_o  = count_i;
        tc_c_o     = 1'b0;
        dir_c_o    = dir_i;
        bstate_c_o = bstate_i;

        if (load_i) begin
            count_c_o = (load_val_i > MAX) ? MAX : load_val_i;
        end else if (en_i) begin
            dir_c_o = up_i;
            case (mode_i)
                MODE_SAT: begin
                    if (up_i) begin
                        if (count_i >= MAX) begin
                            count_c_o = MAX;
                            tc_c_o    = 1'b1;
                        end else begin
                            count_c_o = count_i + ONE;
                        end
                    end else begin
                        if (count_i == '0) begin
                            tc_c_o = 1'b1;
                        end else begin
                            count_c_o = count_i - ONE;
                        end
                    end
                end
                MODE_BOUNCE: begin
                    if (bstate_i == B_UP) begin
                        if (count_i >= MAX) begin
                            bstate_c_o = B_DOWN;
                            count_c_o  = MAX_M1;
                            tc_c_o     = 1'b1;
                        end else begin
                            count_c_o = count_i + ONE;
                        end
                    end else begin
                        if (count_i == '0) begin
                            bstate_c_o = B_UP;
                            count_c_o  = ONE;
                            tc_c_o     = 1'b1;
                        end else begin
                            count_c_o = count_i - ONE;
                        end
                    end
                    // Direction follows the state being entered, so it flips on the turn edge.
                    dir_c_o = (bstate_c_o == B_UP);
                end
                default: begin
                    if (up_i) begin
                        if (count_i >= MAX) begin
                            count_c_o = '0;
                            tc_c_o    = 1'b1;
                        end else begin
                            count_c_o = count_i + ONE;
                        end
                    end else begin
                        if (count_i == '0) begin
                            count_c_o = MAX;
                            tc_c_o    = 1'b1;
                        end else begin
                            count_c_o = count_i - ONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/count_updn.sv
// Up/down counter with wrap, saturate and bounce modes, synchronous load.
// Ports: clk_i, rst_i (async, active-high), en_i, up_i, mode_i[1:0], load_i,
//        load_val_i[WIDTH]; outputs count_o[WIDTH], tc_o, dir_o, all registered.
module count_updn
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             dir_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;
    bounce_state_e    bstate_q, bstate_d;

    count_step #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step (
        .count_i    (count_q),
        .dir_i      (dir_q),
        .bstate_i   (bstate_q),
        .en_i       (en_i),
        .up_i       (up_i),
        .mode_i     (mode_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .count_c_o  (count_d),
        .tc_c_o     (tc_d),
        .dir_c_o    (dir_d),
        .bstate_c_o (bstate_d)
    );

    // State register; bounce state lives here so it survives mode changes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            tc_q     <= 1'b0;
            dir_q    <= 1'b1;
            bstate_q <= B_UP;
        end else begin
            count_q  <= count_d;
            tc_q     <= tc_d;
            dir_q    <= dir_d;
            bstate_q <= bstate_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign dir_o   = dir_q;

endmodule
